// File: rtl/gate_sequencer_if.sv
// Sensor/flag inputs and counter-control outputs of the gate sequencer.
`timescale 1ns/1ps
interface gate_sequencer_if;
  logic       SA;
  logic       SB;
  logic       EF;
  logic       FF;
  logic       UP;
  logic       DOWN;
  logic       REJ;
  logic       ERR;
  logic [2:0] ST;

  modport master (output SA, SB, EF, FF, input UP, DOWN, REJ, ERR, ST);
  modport slave  (input SA, SB, EF, FF, output UP, DOWN, REJ, ERR, ST);
endinterface

// File: rtl/gate_sequencer.sv
// Two-beam doorway direction detector: synchronizes and debounces the photo-sensors,
// tracks entry/exit transits and pulses the occupancy counter.
`timescale 1ns/1ps
module gate_sequencer #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             CLK,
  input  logic             MR,
  gate_sequencer_if.slave  bus
);

  localparam int unsigned DB_W    = 8;
  localparam int unsigned DWELL_W = 16;
  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_A1     = 3'd1,
    S_AB_IN  = 3'd2,
    S_B_IN   = 3'd3,
    S_B1     = 3'd4,
    S_AB_OUT = 3'd5,
    S_A_OUT  = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  logic [1:0]         sa_sync, sb_sync;
  logic [DB_W-1:0]    db_a_q, db_b_q;
  logic               fa, fb;
  state_t             state_q, state_nxt;
  logic [DWELL_W-1:0] dwell_q;
  logic               up_q, down_q, rej_q, err_q;
  logic               up_nxt, down_nxt, rej_nxt;
  logic               transit, timed_out;
  logic [1:0]         ab;

  // Two-flop synchronizers for the asynchronous sensors
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      sa_sync <= 2'b00;
      sb_sync <= 2'b00;
    end else begin
      sa_sync <= {sa_sync[0], bus.SA};
      sb_sync <= {sb_sync[0], bus.SB};
    end
  end

  // Filtered level follows the synchronized level only after DB_CYCLES straight disagreements
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      db_a_q <= '0;
      db_b_q <= '0;
      fa     <= 1'b0;
      fb     <= 1'b0;
    end else begin
      if (sa_sync[1] == fa) begin
        db_a_q <= '0;
      end else if (db_a_q == DB_LAST) begin
        db_a_q <= '0;
        fa     <= sa_sync[1];
      end else begin
        db_a_q <= db_a_q + DB_W'(1);
      end

      if (sb_sync[1] == fb) begin
        db_b_q <= '0;
      end else if (db_b_q == DB_LAST) begin
        db_b_q <= '0;
        fb     <= sb_sync[1];
      end else begin
        db_b_q <= db_b_q + DB_W'(1);
      end
    end
  end

  assign ab        = {fa, fb};
  assign transit   = (state_q != S_IDLE) && (state_q != S_ERR);
  assign timed_out = transit && (dwell_q == DWELL_MAX);

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and completion pulses; a stalled transit overrides sensor decoding
  always_comb begin
    state_nxt = state_q;
    up_nxt    = 1'b0;
    down_nxt  = 1'b0;
    rej_nxt   = 1'b0;
    if (timed_out) begin
      state_nxt = S_ERR;
    end else begin
      case (state_q)
        S_IDLE: begin
          case (ab)
            2'b10:   state_nxt = S_A1;
            2'b01:   state_nxt = S_B1;
            2'b11:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
          endcase
        end
        S_A1: begin
          case (ab)
            2'b11:   state_nxt = S_AB_IN;
            2'b00:   state_nxt = S_IDLE;
            2'b01:   state_nxt = S_ERR;
            default: state_nxt = S_A1;
          endcase
        end
        S_AB_IN: begin
          case (ab)
            2'b01:   state_nxt = S_B_IN;
            2'b10:   state_nxt = S_A1;
            2'b00:   state_nxt = S_ERR;
            default: state_nxt = S_AB_IN;
          endcase
        end
        S_B_IN: begin
          case (ab)
            2'b00: begin
              state_nxt = S_IDLE;
              up_nxt    = !bus.FF;
              rej_nxt   = bus.FF;
            end
            2'b11:   state_nxt = S_AB_IN;
            2'b10:   state_nxt = S_ERR;
            default: state_nxt = S_B_IN;
          endcase
        end
        S_B1: begin
          case (ab)
            2'b11:   state_nxt = S_AB_OUT;
            2'b00:   state_nxt = S_IDLE;
            2'b10:   state_nxt = S_ERR;
            default: state_nxt = S_B1;
          endcase
        end
        S_AB_OUT: begin
          case (ab)
            2'b10:   state_nxt = S_A_OUT;
            2'b01:   state_nxt = S_B1;
            2'b00:   state_nxt = S_ERR;
            default: state_nxt = S_AB_OUT;
          endcase
        end
        S_A_OUT: begin
          case (ab)
            2'b00: begin
              state_nxt = S_IDLE;
              down_nxt  = !bus.EF;
              rej_nxt   = bus.EF;
            end
            2'b11:   state_nxt = S_AB_OUT;
            2'b01:   state_nxt = S_ERR;
            default: state_nxt = S_A_OUT;
          endcase
        end
        default: begin
          if (ab == 2'b00) state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Dwell timer only runs while a transit holds its state
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      dwell_q <= '0;
    end else if (!transit || (state_nxt != state_q)) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      rej_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      up_q   <= up_nxt;
      down_q <= down_nxt;
      rej_q  <= rej_nxt;
      err_q  <= (state_nxt == S_ERR);
    end
  end

  assign bus.UP   = up_q;
  assign bus.DOWN = down_q;
  assign bus.REJ  = rej_q;
  assign bus.ERR  = err_q;
  assign bus.ST   = state_q;

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 4, means consecutive stable cycles required to accept a sensor level change; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 255, means the maximum cycles allowed in any transit state before an error; legal range 1..65535.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- CLK  input  1  system clock, rising edge.
- MR  input  1  master reset; asynchronous, active-low.
- SA  input  1  raw outer photo-sensor; asynchronous to CLK; 1 = beam broken.
- SB  input  1  raw inner photo-sensor; asynchronous to CLK; 1 = beam broken.
- EF  input  1  empty flag from the downstream occupancy counter; active high.
- FF  input  1  full flag from the downstream occupancy counter; active high.
- UP  output  1  registered one-cycle increment pulse to the counter.
- DOWN  output  1  registered one-cycle decrement pulse to the counter.
- REJ  output  1  registered one-cycle pulse when a completed transit is blocked by FF or EF.
- ERR  output  1  registered level; high while the FSM is in ERR.
- ST  output  3  registered current FSM state code.

Function
REQ-004 SA and SB SHALL each pass through a two-flop synchronizer before any other use.
REQ-005 Each synchronized sensor SHALL have a debounce counter:
- The filtered level (fa/fb) SHALL take the synchronized value when that value has differed from the filtered level for DB_CYCLES consecutive cycles.
- Any cycle of agreement SHALL clear the debounce counter.
- Raw edge to filtered change SHALL be exactly 2+DB_CYCLES cycles for a clean edge.
REQ-006 State codes SHALL be: IDLE=0, A1=1, AB_IN=2, B_IN=3, B1=4, AB_OUT=5, A_OUT=6, ERR=7.
REQ-007 Transitions SHALL depend on {fa,fb}. Any value not listed for a state keeps that state.
- IDLE: 10 -> A1; 01 -> B1; 11 -> ERR.
- A1: 11 -> AB_IN; 00 -> IDLE with no pulse; 01 -> ERR.
- AB_IN: 01 -> B_IN; 10 -> A1; 00 -> ERR.
- B_IN: 00 -> IDLE with completed entry; 11 -> AB_IN; 10 -> ERR.
- B1: 11 -> AB_OUT; 00 -> IDLE with no pulse; 10 -> ERR.
- AB_OUT: 10 -> A_OUT; 01 -> B1; 00 -> ERR.
- A_OUT: 00 -> IDLE with completed exit; 11 -> AB_OUT; 01 -> ERR.
- ERR: 00 -> IDLE; anything else stays in ERR.
REQ-008 On a completed entry, the block SHALL assert UP for exactly one cycle if FF=0, else REJ for one cycle. FF SHALL be sampled in the cycle the transition is decided.
REQ-009 On a completed exit, the block SHALL assert DOWN for one cycle if EF=0, else REJ for one cycle.
REQ-010 UP, DOWN and REJ SHALL be asserted in the same cycle ST first shows IDLE, which is one clock after {fa,fb} becomes 00.
REQ-011 UP and DOWN SHALL never be high together, and neither SHALL be high for two consecutive cycles.
REQ-012 A 16-bit dwell timer SHALL clear on every state change and increment otherwise.
- In A1, AB_IN, B_IN, B1, AB_OUT or A_OUT, reaching TIMEOUT SHALL force ERR on the next clock, with priority over REQ-007.
- The timer SHALL be inactive in IDLE and ERR.
REQ-013 ERR SHALL equal (ST==7), and entering ERR SHALL emit no UP, DOWN or REJ.
REQ-014 Both filtered inputs changing in the same cycle SHALL be handled by REQ-007 on the full 2-bit value; there is no special case.

Reset
REQ-015 MR=0 SHALL immediately reset the block, regardless of CLK:
- ST=IDLE.
- UP=DOWN=REJ=ERR=0.
- Synchronizer flops, fa and fb = 0.
- Debounce and dwell counters = 0.
REQ-016 MR asserted mid-transit SHALL abandon the transit with no pulse. After release, the FSM SHALL leave IDLE only per REQ-007.
REQ-017 MR release SHALL take effect at the first rising CLK edge after MR rises.

Verification (DB_CYCLES=4, TIMEOUT=20)
REQ-018 Entry: SA=1, then SB=1, then SA=0, then SB=0, each step held 10 cycles, EF=FF=0 -> ST visits 1,2,3,0; one UP pulse 7 cycles after SB falls; DOWN=REJ=0.
REQ-019 Exit with EF=1: SB, SA, SB release, SA release -> ST visits 4,5,6,0; REJ pulses once; DOWN=0.
REQ-020 Glitch: SA high for 3 cycles, then low -> fa stays 0, ST stays 0, no outputs.
REQ-021 Back-out: SA=1 for 10 cycles, then 0 -> ST goes 1 then 0; no UP, DOWN or REJ.
REQ-022 Stall: SA=1, then SB=1, held 40 cycles -> ST=7 and ERR=1 the cycle after the timer hits 20; release both -> ST=0, ERR=0.
REQ-023 MR pulsed low while ST=3 -> all outputs 0 immediately; SB=0 afterwards produces no UP.
